bus_master: RTL

BUS_MASTER -- requirements
Module: bus_master

---
 rtl/bus_master.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/bus_master.sv
// -----------------------------------------------------------------------------
// bus_master
//
// Word-copy bus master. On a start strobe it latches a source address, a
// destination address and a word count, requests the shared bus, and then
// alternates READ (fetch one word) and WRITE (store that word) until every
// word has been copied. A single-cycle done pulse closes each command.
//
// Bus ownership is requested with m_req and confirmed with m_grant. Losing the
// grant in READ or WRITE sends the engine back to REQ without advancing the
// word index, so the interrupted word is fetched again once ownership returns.
//
// Every output is decoded from registered state and datapath registers only,
// so no input (not even m_grant) has a combinational path to an output. The
// slave side therefore qualifies each access with m_grant. In the one cycle in
// which the grant has already been withdrawn but the engine has not yet left
// READ/WRITE, the address and strobe still show the pending access; the slave
// treats that cycle as "no bus access". The engine itself never counts it as a
// completed word.
// -----------------------------------------------------------------------------
module bus_master #(
    parameter int AW = 16,   // address width
    parameter int DW = 32    // data width
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [7:0]    size,
    input  logic          m_grant,
    input  logic [DW-1:0] m_din,
    output logic          m_req,
    output logic          m_wr,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_dout,
    output logic          busy,
    output logic          done
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        IDLE  = 3'd0,   // waiting for a command
        REQ   = 3'd1,   // requesting / re-requesting the bus
        READ  = 3'd2,   // fetching word idx from the source
        WRITE = 3'd3,   // storing word idx to the destination
        DONE  = 3'd4    // one-cycle completion pulse
    } state_t;

    state_t state;
    state_t state_nxt;

    // -------------------------------------------------------------------------
    // Command and datapath registers
    // -------------------------------------------------------------------------
    logic [AW-1:0] src_q;     // latched first source address
    logic [AW-1:0] dst_q;     // latched first destination address
    logic [7:0]    size_q;    // latched word count (never 0 once latched)
    logic [7:0]    idx;       // index of the word currently being copied
    logic [DW-1:0] data_q;    // word captured in READ, replayed in WRITE

    logic          accept;    // a non-empty command is being taken in IDLE
    logic          last_word; // idx addresses the final word of the command

    assign accept    = (state == IDLE) && start && (size != 8'd0);
    assign last_word = (idx == size_q - 8'd1);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of every other flop; blocking here would make the result
    // depend on statement order and diverge between simulation and synthesis.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: state_nxt gets a default before the case so every path assigns it;
    // a missing assignment on any branch would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                // start outside IDLE is simply never looked at
                if (start) begin
                    state_nxt = (size == 8'd0) ? DONE : REQ;
                end
            end
            REQ: begin
                if (m_grant) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                state_nxt = m_grant ? WRITE : REQ;
            end
            WRITE: begin
                if (!m_grant) begin
                    state_nxt = REQ;
                end else if (last_word) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = READ;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Command latch, word index and read-data capture
    // -------------------------------------------------------------------------
    // idx only advances on a granted WRITE, so a lost grant replays the word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q  <= '0;
            dst_q  <= '0;
            size_q <= '0;
            idx    <= '0;
            data_q <= '0;
        end else begin
            if (accept) begin
                src_q  <= src_addr;
                dst_q  <= dst_addr;
                size_q <= size;
                idx    <= '0;
            end
            if ((state == READ) && m_grant) begin
                data_q <= m_din;
            end
            if ((state == WRITE) && m_grant && !last_word) begin
                idx <= idx + 8'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output decode (registered state and datapath only)
    // -------------------------------------------------------------------------
    // Address sums are AW bits wide, so they wrap modulo 2^AW by construction.
    always_comb begin
        m_req  = 1'b0;
        m_wr   = 1'b0;
        m_addr = '0;
        m_dout = '0;
        busy   = (state != IDLE);
        done   = (state == DONE);
        case (state)
            REQ: begin
                m_req = 1'b1;
            end
            READ: begin
                m_req  = 1'b1;
                m_addr = src_q + AW'(idx);
            end
            WRITE: begin
                m_req  = 1'b1;
                m_wr   = 1'b1;
                m_addr = dst_q + AW'(idx);
                m_dout = data_q;
            end
            default: begin
            end
        endcase
    end

endmodule
